// File: rtl/tx_slot_queue_if.sv
// Request-side and scheduler-side signals of the CCI-P transmit slot queue.
// The master side drives requests and pops; the slave side is tx_slot_queue.
interface tx_slot_queue_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int LNUM_FLOWS  = 1,
  parameter int LFIFO_DEPTH = 3,
  parameter int LSIZE       = LNUM_FLOWS + LFIFO_DEPTH
);
  localparam int F = 1 << LNUM_FLOWS;

  logic                     initialize;
  logic                     initialized;
  logic                     error;
  logic                     push_en;
  logic [DATA_WIDTH-1:0]    push_data;
  logic [LNUM_FLOWS-1:0]    push_flow;
  logic                     push_done;
  logic [LSIZE-1:0]         push_slot_id;
  logic [F*LFIFO_DEPTH-1:0] flow_dw;
  logic                     pop_en;
  logic [LNUM_FLOWS-1:0]    pop_flow;
  logic                     pop_valid;
  logic [DATA_WIDTH-1:0]    pop_data;
  logic [LNUM_FLOWS-1:0]    pop_flow_out;

  modport master (
    output initialize, push_en, push_data, push_flow, pop_en, pop_flow,
    input  initialized, error, push_done, push_slot_id, flow_dw,
           pop_valid, pop_data, pop_flow_out
  );

  modport slave (
    input  initialize, push_en, push_data, push_flow, pop_en, pop_flow,
    output initialized, error, push_done, push_slot_id, flow_dw,
           pop_valid, pop_data, pop_flow_out
  );
endinterface

// File: rtl/tx_slot_queue.sv
// Slot-addressed payload store with a FIFO-ordered free list and one slot-ID FIFO
// per flow; the scheduler pops whole flows and gets payloads back in push order.
module tx_slot_queue #(
  parameter int DATA_WIDTH  = 512,
  parameter int LNUM_FLOWS  = 1,
  parameter int LFIFO_DEPTH = 3,
  parameter int LSIZE       = LNUM_FLOWS + LFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  tx_slot_queue_if.slave sq
);
  localparam int N  = 1 << LSIZE;
  localparam int F  = 1 << LNUM_FLOWS;
  localparam int FD = 1 << LFIFO_DEPTH;
  localparam logic [LFIFO_DEPTH-1:0] CAP    = '1;
  localparam logic [LFIFO_DEPTH-1:0] CAP_M1 = {{(LFIFO_DEPTH-1){1'b1}}, 1'b0};

  // A push still sitting in the allocate stage has not reached its flow FIFO yet.
  function automatic logic flow_full(input logic [LFIFO_DEPTH-1:0] cnt, input logic pend);
    return (cnt == CAP) || (pend && (cnt == CAP_M1));
  endfunction

  logic [DATA_WIDTH-1:0]  r_mem [N];
  logic [LSIZE-1:0]       r_fl_mem [N];
  logic [LSIZE:0]         r_fl_wr, r_fl_rd;
  logic [LSIZE:0]         r_init_cnt;
  logic                   r_building, r_initialized, r_error;

  logic                   r_push_vld_p0;
  logic [LNUM_FLOWS-1:0]  r_push_flow_p0;
  logic [LSIZE-1:0]       r_push_slot_p0;

  logic                   r_pop_vld_p0, r_pop_vld_p1;
  logic [LNUM_FLOWS-1:0]  r_pop_flow_p0, r_pop_flow_p1;
  logic [LSIZE-1:0]       r_pop_slot_p0, r_pop_slot_p1;
  logic [DATA_WIDTH-1:0]  r_pop_data_p1;

  logic                   w_init_start, w_init_wr, w_fl_we, w_fl_empty;
  logic [LSIZE-1:0]       w_init_id, w_fl_wdata, w_fl_head;
  logic                   w_push_pend, w_push_ok, w_pop_ok;
  logic [LFIFO_DEPTH-1:0] w_ff_cnt  [F];
  logic [LSIZE-1:0]       w_ff_head [F];
  logic [F*LFIFO_DEPTH-1:0] w_flow_dw;

  assign w_init_start = sq.initialize && !r_initialized && !r_building;
  assign w_init_wr    = w_init_start || (r_building && !r_init_cnt[LSIZE]);
  assign w_init_id    = w_init_start ? '0 : r_init_cnt[LSIZE-1:0];
  assign w_fl_we      = w_init_wr || r_pop_vld_p1;
  assign w_fl_wdata   = w_init_wr ? w_init_id : r_pop_slot_p1;
  assign w_fl_empty   = (r_fl_wr == r_fl_rd);
  assign w_fl_head    = r_fl_mem[r_fl_rd[LSIZE-1:0]];

  assign w_push_pend = r_push_vld_p0 && (r_push_flow_p0 == sq.push_flow);
  assign w_push_ok   = sq.push_en && r_initialized && !w_fl_empty &&
                       !flow_full(w_ff_cnt[sq.push_flow], w_push_pend);
  assign w_pop_ok    = sq.pop_en && (w_ff_cnt[sq.pop_flow] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_building    <= 1'b0;
      r_initialized <= 1'b0;
      r_init_cnt    <= '0;
      r_fl_wr       <= '0;
      r_fl_rd       <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_init_start) begin
        r_building <= 1'b1;
        r_init_cnt <= (LSIZE+1)'(1);
      end else if (r_building) begin
        if (r_init_cnt[LSIZE]) begin
          r_building    <= 1'b0;
          r_initialized <= 1'b1;
        end else begin
          r_init_cnt <= r_init_cnt + 1'b1;
        end
      end
      if (w_fl_we)   r_fl_wr <= r_fl_wr + 1'b1;
      if (w_push_ok) r_fl_rd <= r_fl_rd + 1'b1;
      if ((sq.push_en && !w_push_ok) || (sq.pop_en && !w_pop_ok)) r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fl_we) r_fl_mem[r_fl_wr[LSIZE-1:0]] <= w_fl_wdata;
  end

  // p0: slot allocated and payload written; slot ID goes to its flow FIFO next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push_vld_p0  <= 1'b0;
      r_push_flow_p0 <= '0;
      r_push_slot_p0 <= '0;
    end else begin
      r_push_vld_p0 <= w_push_ok;
      if (w_push_ok) begin
        r_push_flow_p0 <= sq.push_flow;
        r_push_slot_p0 <= w_fl_head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[w_fl_head] <= sq.push_data;
  end

  for (genvar f = 0; f < F; f++) begin : g_flow
    logic [LSIZE-1:0]       r_q [FD];
    logic [LFIFO_DEPTH-1:0] r_wp, r_rp, r_cnt;
    logic                   w_wr, w_rd;

    assign w_wr = r_push_vld_p0 && (r_push_flow_p0 == LNUM_FLOWS'(f));
    assign w_rd = w_pop_ok && (sq.pop_flow == LNUM_FLOWS'(f));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_wr) r_wp <= r_wp + 1'b1;
        if (w_rd) r_rp <= r_rp + 1'b1;
        if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
        else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr) r_q[r_wp] <= r_push_slot_p0;
    end

    assign w_ff_cnt[f]  = r_cnt;
    assign w_ff_head[f] = r_q[r_rp];
    assign w_flow_dw[f*LFIFO_DEPTH +: LFIFO_DEPTH] = r_cnt;
  end

  // p0: head slot ID taken from the flow FIFO; p1: payload read, slot freed next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pop_vld_p0  <= 1'b0;
      r_pop_flow_p0 <= '0;
      r_pop_slot_p0 <= '0;
      r_pop_vld_p1  <= 1'b0;
      r_pop_flow_p1 <= '0;
      r_pop_slot_p1 <= '0;
      r_pop_data_p1 <= '0;
    end else begin
      r_pop_vld_p0 <= w_pop_ok;
      if (w_pop_ok) begin
        r_pop_flow_p0 <= sq.pop_flow;
        r_pop_slot_p0 <= w_ff_head[sq.pop_flow];
      end
      r_pop_vld_p1 <= r_pop_vld_p0;
      if (r_pop_vld_p0) begin
        r_pop_flow_p1 <= r_pop_flow_p0;
        r_pop_slot_p1 <= r_pop_slot_p0;
        r_pop_data_p1 <= r_mem[r_pop_slot_p0];
      end
    end
  end

  assign sq.initialized  = r_initialized;
  assign sq.error        = r_error;
  assign sq.push_done    = r_push_vld_p0;
  assign sq.push_slot_id = r_push_slot_p0;
  assign sq.flow_dw      = w_flow_dw;
  assign sq.pop_valid    = r_pop_vld_p1;
  assign sq.pop_data     = r_pop_data_p1;
  assign sq.pop_flow_out = r_pop_flow_p1;
endmodule

// File: tb/tb_tx_slot_queue.sv
// Scoreboard bench for tx_slot_queue: a reference free list and per-flow queues
// predict slot IDs, payload order and the sticky error flag.
module tb_tx_slot_queue;
  localparam int DW  = 512;
  localparam int LNF = 1;
  localparam int LFD = 3;
  localparam int LS  = 4;
  localparam int N   = 16;
  localparam int CAP = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tx_slot_queue_if #(.DATA_WIDTH(DW), .LNUM_FLOWS(LNF), .LFIFO_DEPTH(LFD), .LSIZE(LS)) sq_if ();

  tx_slot_queue #(.DATA_WIDTH(DW), .LNUM_FLOWS(LNF), .LFIFO_DEPTH(LFD), .LSIZE(LS)) dut (
    .clk   (clk),
    .reset (reset),
    .sq    (sq_if.slave)
  );

  typedef struct packed { logic [LS-1:0] slot; logic [DW-1:0] data; } ent_t;
  typedef struct packed { logic [LNF-1:0] flow; logic [DW-1:0] data; } pop_t;

  ent_t          mq0[$], mq1[$];
  int            fl_q[$];
  logic [LS-1:0] exp_slot_q[$];
  pop_t          exp_pop_q[$];
  bit            model_init, exp_err;
  int            n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int dw(input int f);
    return int'(sq_if.flow_dw[f*LFD +: LFD]);
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin : mon
    logic [LS-1:0] s;
    pop_t          p;
    #1;
    if (!reset) begin
      if (sq_if.push_done) begin
        if (exp_slot_q.size() == 0) chk("push_done_unexpected", DW'(sq_if.push_done), DW'(0));
        else begin
          s = exp_slot_q.pop_front();
          chk("push_slot_id", DW'(sq_if.push_slot_id), DW'(s));
        end
      end
      if (sq_if.pop_valid) begin
        if (exp_pop_q.size() == 0) chk("pop_valid_unexpected", DW'(sq_if.pop_valid), DW'(0));
        else begin
          p = exp_pop_q.pop_front();
          chk("pop_data", sq_if.pop_data, p.data);
          chk("pop_flow_out", DW'(sq_if.pop_flow_out), DW'(p.flow));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cyc(input bit pe, input int pf, input logic [DW-1:0] pd, input bit qe, input int qf);
    ent_t e;
    pop_t p;
    int   sz_push, sz_pop, sz_fl;
    sq_if.push_en   = pe;
    sq_if.push_flow = LNF'(pf);
    sq_if.push_data = pd;
    sq_if.pop_en    = qe;
    sq_if.pop_flow  = LNF'(qf);
    sz_push = (pf == 0) ? mq0.size() : mq1.size();
    sz_pop  = (qf == 0) ? mq0.size() : mq1.size();
    sz_fl   = fl_q.size();
    if (qe) begin
      if (sz_pop == 0) exp_err = 1'b1;
      else begin
        if (qf == 0) e = mq0.pop_front();
        else         e = mq1.pop_front();
        p.flow = LNF'(qf);
        p.data = e.data;
        exp_pop_q.push_back(p);
        fl_q.push_back(int'(e.slot));
      end
    end
    if (pe) begin
      if (!model_init || sz_fl == 0 || sz_push >= CAP) exp_err = 1'b1;
      else begin
        e.slot = LS'(fl_q.pop_front());
        e.data = pd;
        exp_slot_q.push_back(e.slot);
        if (pf == 0) mq0.push_back(e);
        else         mq1.push_back(e);
      end
    end
    @(negedge clk);
    sq_if.push_en = 1'b0;
    sq_if.pop_en  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sq_if.initialize = 1'b0;
    sq_if.push_en    = 1'b0;
    sq_if.pop_en     = 1'b0;
    idle(2);
    reset = 1'b0;
    mq0.delete(); mq1.delete(); fl_q.delete();
    exp_slot_q.delete(); exp_pop_q.delete();
    model_init = 1'b0;
    exp_err    = 1'b0;
    chk("rst_initialized", DW'(sq_if.initialized), DW'(0));
    chk("rst_error", DW'(sq_if.error), DW'(0));
    chk("rst_push_done", DW'(sq_if.push_done), DW'(0));
    chk("rst_pop_valid", DW'(sq_if.pop_valid), DW'(0));
    chk("rst_push_slot_id", DW'(sq_if.push_slot_id), DW'(0));
    chk("rst_pop_data", sq_if.pop_data, DW'(0));
    chk("rst_flow_dw", DW'(sq_if.flow_dw), DW'(0));
  endtask

  task automatic do_init();
    sq_if.initialize = 1'b1;
    @(negedge clk);
    sq_if.initialize = 1'b0;
    idle(N-1);
    chk("init_early", DW'(sq_if.initialized), DW'(0));
    @(negedge clk);
    chk("init_done", DW'(sq_if.initialized), DW'(1));
    chk("init_error", DW'(sq_if.error), DW'(0));
    for (int i = 0; i < N; i++) fl_q.push_back(i);
    model_init = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sq_if.initialize = 1'b0;
    sq_if.push_en    = 1'b0;
    sq_if.push_data  = '0;
    sq_if.push_flow  = '0;
    sq_if.pop_en     = 1'b0;
    sq_if.pop_flow   = '0;

    // Single push/pop with cycle-exact timing, then a redundant initialize.
    do_reset();
    do_init();
    cyc(1, 0, DW'(32'hA), 0, 0);
    chk("single_push_done_t1", DW'(sq_if.push_done), DW'(1));
    chk("single_dw_t1", DW'(dw(0)), DW'(0));
    idle(1);
    chk("single_dw_t2", DW'(dw(0)), DW'(1));
    cyc(0, 0, '0, 1, 0);
    chk("single_dw_pop_t1", DW'(dw(0)), DW'(0));
    chk("single_pop_valid_t1", DW'(sq_if.pop_valid), DW'(0));
    idle(1);
    chk("single_pop_valid_t2", DW'(sq_if.pop_valid), DW'(1));
    idle(2);
    sq_if.initialize = 1'b1;
    @(negedge clk);
    sq_if.initialize = 1'b0;
    cyc(1, 1, rnd(), 0, 0);
    idle(3);
    cyc(0, 0, '0, 1, 1);
    idle(3);
    chk("single_error", DW'(sq_if.error), DW'(exp_err));

    // Interleaved flows: B, A, C come back out.
    do_reset();
    do_init();
    cyc(1, 0, DW'(32'hA), 0, 0);
    cyc(1, 1, DW'(32'hB), 0, 0);
    cyc(1, 0, DW'(32'hC), 0, 0);
    idle(3);
    chk("ilv_dw0", DW'(dw(0)), DW'(2));
    chk("ilv_dw1", DW'(dw(1)), DW'(1));
    cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);
    idle(4);
    chk("ilv_error", DW'(sq_if.error), DW'(exp_err));

    // Full flow FIFO: 8th push rejected, slot 7 stays on the free list.
    do_reset();
    do_init();
    for (int i = 0; i < 8; i++) cyc(1, 0, rnd(), 0, 0);
    idle(3);
    chk("full_dw0", DW'(dw(0)), DW'(CAP));
    chk("full_error", DW'(sq_if.error), DW'(exp_err));
    cyc(0, 0, '0, 1, 0);
    idle(3);
    cyc(1, 0, rnd(), 0, 0);
    idle(3);
    chk("full_dw0_refill", DW'(dw(0)), DW'(CAP));

    // Pop from an empty flow.
    do_reset();
    do_init();
    cyc(0, 0, '0, 1, 1);
    idle(1);
    chk("empty_pop_valid", DW'(sq_if.pop_valid), DW'(0));
    idle(2);
    chk("empty_error", DW'(sq_if.error), DW'(exp_err));

    // Slot reuse over 16 requests across both flows, with concurrent push/pop.
    do_reset();
    do_init();
    for (int i = 0; i < 8; i++) cyc(1, i % 2, rnd(), 0, 0);
    idle(3);
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 1, i % 2);
    idle(3);
    for (int i = 0; i < 4; i++) cyc(1, i % 2, rnd(), 0, 0);
    idle(3);
    for (int i = 0; i < 4; i++) cyc(1, i % 2, rnd(), 1, i % 2);
    idle(3);
    chk("reuse_dw0_mid", DW'(dw(0)), DW'(2));
    chk("reuse_dw1_mid", DW'(dw(1)), DW'(2));
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, i % 2);
    idle(4);
    cyc(1, 0, rnd(), 0, 0);
    idle(3);
    chk("reuse_dw0_end", DW'(dw(0)), DW'(1));
    chk("reuse_dw1_end", DW'(dw(1)), DW'(0));
    chk("reuse_error", DW'(sq_if.error), DW'(exp_err));
    chk("sb_slot_drain", DW'(exp_slot_q.size()), DW'(0));
    chk("sb_pop_drain", DW'(exp_pop_q.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
